// File: rtl/leds_pwm_multi_if.sv
// leds_pwm_multi_if: duty/select/window controls and LED/status returns of the LED PWM driver
interface leds_pwm_multi_if #(
    parameter int NCH = 3,
    parameter int DW = 5,
    parameter int CW = 16
);
    logic [NCH*DW-1:0] DUTY;
    logic [NCH-1:0] SEL;
    logic START;
    logic END;
    logic [NCH-1:0] LED;
    logic BUSY;
    logic [CW-1:0] PCNT;
    modport master (output DUTY, SEL, START, END, input LED, BUSY, PCNT);
    modport slave (input DUTY, SEL, START, END, output LED, BUSY, PCNT);
endinterface

// File: rtl/leds_pwm_multi.sv
// leds_pwm_multi: multi-channel LED PWM lit inside a START/END window, duty applied at period boundaries; define LED_PWM_STAGGER_EN to phase-shift channels across the period
module leds_pwm_multi #(
    parameter int NCH = 3,
    parameter int DW = 5,
    parameter int PERIOD = 16,
    parameter int CW = 16,
    parameter int ACTIVE_LOW = 1
) (
    input logic CLK,
    input logic RST,
    leds_pwm_multi_if.slave bus
);
    localparam int CNTW = $clog2(PERIOD + 1);
    localparam int PW = CNTW + 1;
    localparam int CMPW = DW > PW ? DW : PW;

    logic [CNTW-1:0] cnt;
    logic start_d;
    logic en_r;
    logic rise;
    logic wrap;
    logic [NCH-1:0] sel_r;
    logic [NCH-1:0] on;
    logic [NCH-1:0] lit;
    logic [DW-1:0] duty_act [NCH];
    logic [CW-1:0] pcnt;

    assign rise = bus.START & ~start_d;
    assign wrap = cnt == CNTW'(PERIOD);
    assign bus.BUSY = en_r;
    assign bus.PCNT = pcnt;
    assign bus.LED = ACTIVE_LOW != 0 ? ~on : on;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [PW-1:0] pc;
`ifdef LED_PWM_STAGGER_EN
        // shift the count by i*(PERIOD/NCH) and fold back into 1..PERIOD
        logic [PW-1:0] sum;
        assign sum = PW'(cnt) + PW'(i * (PERIOD / NCH));
        assign pc = sum > PW'(PERIOD) ? sum - PW'(PERIOD) : sum;
`else
        assign pc = PW'(cnt);
`endif
        assign lit[i] = CMPW'(duty_act[i]) >= CMPW'(pc);
    end

    // window control, free-running period counter, shadowed duties, period count and registered LED drive
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_d <= 1'b0;
            en_r <= 1'b0;
            cnt <= CNTW'(1);
            sel_r <= '0;
            pcnt <= '0;
            on <= '0;
            for (int k = 0; k < NCH; k++) duty_act[k] <= '0;
        end else begin
            start_d <= bus.START;
            en_r <= bus.END ? 1'b0 : (rise ? 1'b1 : en_r);
            cnt <= (rise | wrap) ? CNTW'(1) : cnt + CNTW'(1);
            on <= {NCH{en_r & ~bus.END}} & sel_r & lit;
            if (rise | wrap)
                for (int k = 0; k < NCH; k++) duty_act[k] <= bus.DUTY[k*DW +: DW];
            if (rise) begin
                sel_r <= bus.SEL;
                pcnt <= '0;
            end else if (en_r & wrap & ~bus.END & ~&pcnt) begin
                pcnt <= pcnt + CW'(1);
            end
        end
    end
endmodule
